// File: rtl/snake_pkg.sv
// Shared constants, FSM state encoding and LFSR tap table for the snake target logic.
// Tap masks use bit k-1 for tap k, giving maximal-length sequences for widths 8..32.
package snake_pkg;

  localparam int GRID_H = 160;
  localparam int GRID_V = 120;

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    QUERY,
    WAIT,
    SCAN_INIT,
    SCAN_STEP,
    COMMIT,
    FULL
  } state_e;

  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] m;
    case (width)
      8:       m = 32'h0000_00B8;
      9:       m = 32'h0000_0110;
      10:      m = 32'h0000_0240;
      11:      m = 32'h0000_0500;
      12:      m = 32'h0000_0829;
      13:      m = 32'h0000_100D;
      14:      m = 32'h0000_2015;
      15:      m = 32'h0000_6000;
      16:      m = 32'h0000_D008;
      17:      m = 32'h0001_2000;
      18:      m = 32'h0002_0400;
      19:      m = 32'h0004_0023;
      20:      m = 32'h0009_0000;
      21:      m = 32'h0014_0000;
      22:      m = 32'h0030_0000;
      23:      m = 32'h0042_0000;
      24:      m = 32'h00E1_0000;
      25:      m = 32'h0120_0000;
      26:      m = 32'h0200_0023;
      27:      m = 32'h0400_0013;
      28:      m = 32'h0900_0000;
      29:      m = 32'h1400_0000;
      30:      m = 32'h2000_0029;
      31:      m = 32'h4800_0000;
      32:      m = 32'h8020_0003;
      default: m = 32'h0000_00B8;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lfsr_prng.sv
// Free-running Fibonacci LFSR: shifts left, XOR of the tapped bits feeds bit 0.
// Q exposes the low OUT_W bits so callers only see the bits they consume.
module lfsr_prng
  import snake_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1),
  parameter int               OUT_W = WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  output logic [OUT_W-1:0] Q
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (EN) q_d = {q_q[WIDTH-2:0], ^(q_q & TAPS)};
  end

  always_ff @(posedge CLK) begin
    if (RESET) q_q <= SEED;
    else       q_q <= q_d;
  end

  assign Q = q_q[OUT_W-1:0];

endmodule

// File: rtl/target_placer.sv
// Places a food target on a free grid cell: rejection-sampled random draws, raster-scan fallback.
// Best case: request edge in cycle n -> TARGET_VALID in cycle n+4; waits indefinitely on OCC_VALID.
module target_placer
  import snake_pkg::*;
#(
  parameter int                H_CELLS   = GRID_H,
  parameter int                V_CELLS   = GRID_V,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(16'hACE1),
  parameter int                MAX_TRIES = 8,
  parameter int                INIT_H    = 0,
  parameter int                INIT_V    = 0,
  localparam int               H_BITS    = $clog2(H_CELLS),
  localparam int               V_BITS    = $clog2(V_CELLS)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REACHED,
  input  logic              OCC_VALID,
  input  logic              OCCUPIED,
  output logic              CAND_VALID,
  output logic [H_BITS-1:0] CAND_H,
  output logic [V_BITS-1:0] CAND_V,
  output logic [H_BITS-1:0] TARGET_H,
  output logic [V_BITS-1:0] TARGET_V,
  output logic              TARGET_VALID,
  output logic              BUSY,
  output logic              GRID_FULL
);

  localparam int CW    = H_BITS + V_BITS;
  localparam int CELLS = H_CELLS * V_CELLS;
  localparam int SCW   = $clog2(CELLS + 1);
  localparam int TW    = $clog2(MAX_TRIES + 1);

  // One extra bit so a grid dimension that is an exact power of two still compares correctly.
  localparam logic [H_BITS:0]     H_LIM   = (H_BITS + 1)'(H_CELLS);
  localparam logic [V_BITS:0]     V_LIM   = (V_BITS + 1)'(V_CELLS);
  localparam logic [H_BITS-1:0]   H_LAST  = H_BITS'(H_CELLS - 1);
  localparam logic [V_BITS-1:0]   V_LAST  = V_BITS'(V_CELLS - 1);
  localparam logic [SCW-1:0]      SC_LIM  = SCW'(CELLS);
  localparam logic [TW-1:0]       TRY_LIM = TW'(MAX_TRIES);

  logic [CW-1:0]     rnd;
  logic [H_BITS-1:0] rnd_h;
  logic [V_BITS-1:0] rnd_v;
  logic              rnd_ok;
  logic [TW-1:0]     tries_inc;
  logic [SCW-1:0]    scan_inc;

  state_e            state_q, state_d;
  logic [TW-1:0]     tries_q, tries_d;
  logic [SCW-1:0]    scan_cnt_q, scan_cnt_d;
  logic              scan_mode_q, scan_mode_d;
  logic              reached_q, reached_d;
  logic              cand_valid_q, cand_valid_d;
  logic [H_BITS-1:0] cand_h_q, cand_h_d;
  logic [V_BITS-1:0] cand_v_q, cand_v_d;
  logic [H_BITS-1:0] target_h_q, target_h_d;
  logic [V_BITS-1:0] target_v_q, target_v_d;
  logic              target_valid_q, target_valid_d;
  logic              busy_q, busy_d;
  logic              grid_full_q, grid_full_d;

  lfsr_prng #(
    .WIDTH (LFSR_W),
    .SEED  (SEED),
    .OUT_W (CW)
  ) u_lfsr (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (1'b1),
    .Q     (rnd)
  );

  assign rnd_h     = rnd[H_BITS-1:0];
  assign rnd_v     = rnd[CW-1:H_BITS];
  assign rnd_ok    = ({1'b0, rnd_h} < H_LIM) && ({1'b0, rnd_v} < V_LIM);
  assign tries_inc = tries_q + TW'(1);
  assign scan_inc  = scan_cnt_q + SCW'(1);

  always_comb begin
    state_d        = state_q;
    tries_d        = tries_q;
    scan_cnt_d     = scan_cnt_q;
    scan_mode_d    = scan_mode_q;
    reached_d      = REACHED;
    cand_valid_d   = 1'b0;
    cand_h_d       = cand_h_q;
    cand_v_d       = cand_v_q;
    target_h_d     = target_h_q;
    target_v_d     = target_v_q;
    target_valid_d = 1'b0;
    busy_d         = busy_q;
    grid_full_d    = grid_full_q;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (REACHED && !reached_q) begin
          state_d     = DRAW;
          tries_d     = '0;
          scan_mode_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      DRAW: begin
        cand_h_d = rnd_h;
        cand_v_d = rnd_v;
        if (rnd_ok) begin
          state_d      = QUERY;
          cand_valid_d = 1'b1;
        end else begin
          tries_d = tries_inc;
          if (tries_inc == TRY_LIM) state_d = SCAN_INIT;
        end
      end
      QUERY: state_d = WAIT;
      WAIT: begin
        if (OCC_VALID) begin
          if (!OCCUPIED) begin
            state_d        = COMMIT;
            target_h_d     = cand_h_q;
            target_v_d     = cand_v_q;
            target_valid_d = 1'b1;
            grid_full_d    = 1'b0;
          end else if (!scan_mode_q) begin
            tries_d = tries_inc;
            state_d = (tries_inc == TRY_LIM) ? SCAN_INIT : DRAW;
          end else begin
            scan_cnt_d = scan_inc;
            if (scan_inc == SC_LIM) begin
              state_d     = FULL;
              grid_full_d = 1'b1;
            end else begin
              state_d = SCAN_STEP;
            end
          end
        end
      end
      SCAN_INIT: begin
        cand_h_d     = '0;
        cand_v_d     = '0;
        scan_cnt_d   = '0;
        scan_mode_d  = 1'b1;
        state_d      = QUERY;
        cand_valid_d = 1'b1;
      end
      SCAN_STEP: begin
        if (cand_h_q == H_LAST) begin
          cand_h_d = '0;
          cand_v_d = (cand_v_q == V_LAST) ? '0 : cand_v_q + V_BITS'(1);
        end else begin
          cand_h_d = cand_h_q + H_BITS'(1);
        end
        state_d      = QUERY;
        cand_valid_d = 1'b1;
      end
      COMMIT: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      FULL: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= IDLE;
      tries_q        <= '0;
      scan_cnt_q     <= '0;
      scan_mode_q    <= 1'b0;
      reached_q      <= 1'b0;
      cand_valid_q   <= 1'b0;
      cand_h_q       <= '0;
      cand_v_q       <= '0;
      target_h_q     <= H_BITS'(INIT_H);
      target_v_q     <= V_BITS'(INIT_V);
      target_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      grid_full_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      tries_q        <= tries_d;
      scan_cnt_q     <= scan_cnt_d;
      scan_mode_q    <= scan_mode_d;
      reached_q      <= reached_d;
      cand_valid_q   <= cand_valid_d;
      cand_h_q       <= cand_h_d;
      cand_v_q       <= cand_v_d;
      target_h_q     <= target_h_d;
      target_v_q     <= target_v_d;
      target_valid_q <= target_valid_d;
      busy_q         <= busy_d;
      grid_full_q    <= grid_full_d;
    end
  end

  assign CAND_VALID   = cand_valid_q;
  assign CAND_H       = cand_h_q;
  assign CAND_V       = cand_v_q;
  assign TARGET_H     = target_h_q;
  assign TARGET_V     = target_v_q;
  assign TARGET_VALID = target_valid_q;
  assign BUSY         = busy_q;
  assign GRID_FULL    = grid_full_q;

endmodule

// File: tb/tb_target_placer.sv
// Bench for target_placer: default 160x120 instance (a_*) and a 5x3 / 8-bit LFSR / 4-try instance (b_*).
// Expected candidate/target sequences come from a cycle-level placement model driven by a reference LFSR.
module tb_target_placer;

  typedef struct {
    int cyc;
    int h;
    int v;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_reached, a_occ_v, a_occ, a_cv, a_tvld, a_busy, a_full;
  logic [7:0] a_ch, a_th;
  logic [6:0] a_cvv, a_tv;
  logic       b_reached, b_occ_v, b_occ, b_cv, b_tvld, b_busy, b_full;
  logic [2:0] b_ch, b_th;
  logic [1:0] b_cvv, b_tv;

  target_placer u_a (
    .CLK(clk), .RESET(rst), .REACHED(a_reached), .OCC_VALID(a_occ_v), .OCCUPIED(a_occ),
    .CAND_VALID(a_cv), .CAND_H(a_ch), .CAND_V(a_cvv), .TARGET_H(a_th), .TARGET_V(a_tv),
    .TARGET_VALID(a_tvld), .BUSY(a_busy), .GRID_FULL(a_full)
  );

  target_placer #(
    .H_CELLS(5), .V_CELLS(3), .LFSR_W(8), .SEED(8'hE1), .MAX_TRIES(4)
  ) u_b (
    .CLK(clk), .RESET(rst), .REACHED(b_reached), .OCC_VALID(b_occ_v), .OCCUPIED(b_occ),
    .CAND_VALID(b_cv), .CAND_H(b_ch), .CAND_V(b_cvv), .TARGET_H(b_th), .TARGET_V(b_tv),
    .TARGET_VALID(b_tvld), .BUSY(b_busy), .GRID_FULL(b_full)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference LFSR: shift left, parity of the standard maximal taps enters bit 0.
  function automatic logic [31:0] lstep(input logic [31:0] v, input int w);
    logic [31:0] mask;
    mask = (w == 16) ? 32'h0000_D008 : 32'h0000_00B8;
    return ((v << 1) | {31'd0, ^(v & mask)}) & ((32'd1 << w) - 32'd1);
  endfunction

  int          cyc = 0;
  logic [31:0] ma = 32'h0, mb = 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    ma  <= rst ? 32'h0000_ACE1 : lstep(ma, 16);
    mb  <= rst ? 32'h0000_00E1 : lstep(mb, 8);
  end

  // 0: every cell free, 1: every cell occupied, 2: only (2,1) free
  function automatic bit occ_fn(input int mode, input int h, input int v);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return !(h == 2 && v == 1);
  endfunction

  int resp_mode = 0;
  int resp_lat = 1;
  int r_cnt[2] = '{0, 0};
  bit r_ans[2] = '{0, 0};

  initial begin
    a_occ_v = 0; a_occ = 0; b_occ_v = 0; b_occ = 0;
    forever begin
      @(posedge clk); #1;
      a_occ_v = 0;
      if (r_cnt[0] > 0) begin
        r_cnt[0]--;
        if (r_cnt[0] == 0) begin a_occ_v = 1; a_occ = r_ans[0]; end
      end
      if (a_cv) begin r_cnt[0] = resp_lat; r_ans[0] = occ_fn(resp_mode, int'(a_ch), int'(a_cvv)); end
      b_occ_v = 0;
      if (r_cnt[1] > 0) begin
        r_cnt[1]--;
        if (r_cnt[1] == 0) begin b_occ_v = 1; b_occ = r_ans[1]; end
      end
      if (b_cv) begin r_cnt[1] = resp_lat; r_ans[1] = occ_fn(resp_mode, int'(b_ch), int'(b_cvv)); end
    end
  end

  ev_t act_c[$];
  ev_t act_t[$];

  always @(negedge clk) begin
    if (a_cv)   act_c.push_back('{cyc, int'(a_ch), int'(a_cvv)});
    if (b_cv)   act_c.push_back('{cyc, int'(b_ch), int'(b_cvv)});
    if (a_tvld) act_t.push_back('{cyc, int'(a_th), int'(a_tv)});
    if (b_tvld) act_t.push_back('{cyc, int'(b_th), int'(b_tv)});
  end

  function automatic int busy_of(input int sel);
    return (sel != 0) ? int'(b_busy) : int'(a_busy);
  endfunction
  function automatic int full_of(input int sel);
    return (sel != 0) ? int'(b_full) : int'(a_full);
  endfunction
  function automatic int th_of(input int sel);
    return (sel != 0) ? int'(b_th) : int'(a_th);
  endfunction
  function automatic int tv_of(input int sel);
    return (sel != 0) ? int'(b_tv) : int'(a_tv);
  endfunction

  task automatic set_reached(input int sel, input logic val);
    if (sel != 0) b_reached = val;
    else          a_reached = val;
  endtask

  ev_t exp_c[$];
  ev_t exp_tv;
  bit  exp_full;
  int  exp_idle;
  int  last_h[2] = '{0, 0};
  int  last_v[2] = '{0, 0};

  // Walks the placement rules forward from a request sampled in cycle n.
  task automatic predict(input int sel, input int n, input int lat, input int mode);
    int H, V, HB, VB, W, MT;
    int t, ct, tries, cnt, h, v, resp;
    bit scan, done;
    logic [31:0] cv;
    H  = (sel != 0) ? 5 : 160;
    V  = (sel != 0) ? 3 : 120;
    HB = (sel != 0) ? 3 : 8;
    VB = (sel != 0) ? 2 : 7;
    W  = (sel != 0) ? 8 : 16;
    MT = (sel != 0) ? 4 : 8;
    exp_c.delete();
    exp_full = 0;
    exp_tv = '{-1, -1, -1};
    cv = (sel != 0) ? mb : ma;
    ct = n;
    t = n + 1;
    tries = 0; cnt = 0; scan = 0; done = 0;
    while (!done) begin
      if (!scan) begin
        while (ct < t) begin cv = lstep(cv, W); ct++; end
        h = int'(cv & ((32'd1 << HB) - 32'd1));
        v = int'((cv >> HB) & ((32'd1 << VB) - 32'd1));
        if (h < H && v < V) begin
          resp = t + 1 + lat;
          exp_c.push_back('{t + 1, h, v});
          if (!occ_fn(mode, h, v)) begin
            exp_tv = '{resp + 1, h, v}; exp_idle = resp + 2; done = 1;
          end else begin
            tries++; t = resp + 1;
            if (tries == MT) scan = 1;
          end
        end else begin
          tries++; t = t + 1;
          if (tries == MT) scan = 1;
        end
      end else begin
        h = cnt % H;
        v = cnt / H;
        resp = t + 1 + lat;
        exp_c.push_back('{t + 1, h, v});
        if (!occ_fn(mode, h, v)) begin
          exp_tv = '{resp + 1, h, v}; exp_idle = resp + 2; done = 1;
        end else begin
          cnt++; t = resp + 1;
          if (cnt == H * V) begin exp_full = 1; exp_idle = resp + 2; done = 1; end
        end
      end
    end
  endtask

  task automatic run_txn(input int sel, input int mode, input int lat, input bit dbl);
    int n, base_c, base_t, k, H, V;
    H = (sel != 0) ? 5 : 160;
    V = (sel != 0) ? 3 : 120;
    resp_mode = mode;
    resp_lat = lat;
    @(posedge clk); #1;
    chk("busy_before_req", busy_of(sel), 0);
    base_c = act_c.size();
    base_t = act_t.size();
    n = cyc;
    predict(sel, n, lat, mode);
    set_reached(sel, 1'b1);
    @(posedge clk); #1;
    set_reached(sel, 1'b0);
    if (dbl) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      set_reached(sel, 1'b1);
    end
    k = 0;
    while (busy_of(sel) != 0 && k < 5000) begin @(negedge clk); k++; end
    chk("idle_cycle", cyc, exp_idle);
    @(posedge clk); #1;
    chk("n_cand", act_c.size() - base_c, exp_c.size());
    for (int i = 0; i < exp_c.size() && base_c + i < act_c.size(); i++) begin
      chk("cand_cyc", act_c[base_c + i].cyc, exp_c[i].cyc);
      chk("cand_h", act_c[base_c + i].h, exp_c[i].h);
      chk("cand_v", act_c[base_c + i].v, exp_c[i].v);
      chk("cand_in_grid", (act_c[base_c + i].h < H && act_c[base_c + i].v < V) ? 1 : 0, 1);
    end
    if (exp_full) begin
      chk("tv_count_full", act_t.size() - base_t, 0);
      chk("grid_full_set", full_of(sel), 1);
    end else begin
      chk("tv_count", act_t.size() - base_t, 1);
      if (act_t.size() > base_t) begin
        chk("tv_cyc", act_t[base_t].cyc, exp_tv.cyc);
        chk("tv_h", act_t[base_t].h, exp_tv.h);
        chk("tv_v", act_t[base_t].v, exp_tv.v);
      end
      chk("grid_full_clr", full_of(sel), 0);
      last_h[sel] = exp_tv.h;
      last_v[sel] = exp_tv.v;
    end
    chk("target_h", th_of(sel), last_h[sel]);
    chk("target_v", tv_of(sel), last_v[sel]);
    if (dbl) begin
      set_reached(sel, 1'b0);
      base_c = act_c.size();
      repeat (4) begin
        @(posedge clk); #1;
        chk("no_retrigger_busy", busy_of(sel), 0);
      end
      chk("no_retrigger_cand", act_c.size() - base_c, 0);
    end
  endtask

  initial begin
    int k, base_c, base_t;
    rst = 1'b1;
    a_reached = 1'b0;
    b_reached = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_a_th", a_th, 0);      chk("rst_a_tv", a_tv, 0);
    chk("rst_a_tvld", a_tvld, 0);  chk("rst_a_cv", a_cv, 0);
    chk("rst_a_busy", a_busy, 0);  chk("rst_a_full", a_full, 0);
    chk("rst_a_ch", a_ch, 0);      chk("rst_a_cvv", a_cvv, 0);
    chk("rst_b_th", b_th, 0);      chk("rst_b_tv", b_tv, 0);
    chk("rst_b_tvld", b_tvld, 0);  chk("rst_b_cv", b_cv, 0);
    chk("rst_b_busy", b_busy, 0);  chk("rst_b_full", b_full, 0);

    repeat (1000) run_txn(0, 0, 1, 1'b0);
    repeat (200) run_txn(1, 0, 1, 1'b0);

    run_txn(1, 2, 1, 1'b0);
    chk("only_free_h", b_th, 2);
    chk("only_free_v", b_tv, 1);

    run_txn(1, 1, 1, 1'b0);
    run_txn(1, 0, 1, 1'b0);
    run_txn(1, 0, 3, 1'b1);

    // Reset while waiting on a slow response; the response then lands in IDLE.
    resp_mode = 0;
    resp_lat = 3;
    @(posedge clk); #1;
    b_reached = 1'b1;
    @(posedge clk); #1;
    b_reached = 1'b0;
    k = 0;
    while (!b_cv && k < 100) begin @(posedge clk); #1; k++; end
    chk("rw_cand_seen", b_cv, 1);
    @(posedge clk); #1;
    chk("rw_busy_in_wait", b_busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rw_busy", b_busy, 0);  chk("rw_cv", b_cv, 0);
    chk("rw_ch", b_ch, 0);      chk("rw_cvv", b_cvv, 0);
    chk("rw_th", b_th, 0);      chk("rw_tv", b_tv, 0);
    chk("rw_tvld", b_tvld, 0);  chk("rw_full", b_full, 0);
    last_h[0] = 0; last_v[0] = 0;
    last_h[1] = 0; last_v[1] = 0;
    base_c = act_c.size();
    base_t = act_t.size();
    repeat (6) begin
      @(posedge clk); #1;
      chk("late_occ_busy", b_busy, 0);
    end
    chk("late_occ_tv", act_t.size() - base_t, 0);
    chk("late_occ_cand", act_c.size() - base_c, 0);

    run_txn(1, 0, 1, 1'b0);
    run_txn(0, 0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
